// File: rtl/ssd_display_ctrl_if.sv
`default_nettype none
// ============================================================================
// ssd_display_ctrl_if : status-word valid/ready handshake into the 7-seg ctrl
// Rev 1.0 - initial release
// ============================================================================
interface ssd_display_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    data_valid;
    logic                    data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface
`default_nettype wire

// File: rtl/ssd_display_ctrl.sv
`default_nettype none
// ============================================================================
// ssd_display_ctrl : sweeps one shared hex decoder across NUM_DIGITS fields
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 kept).
// Rev 1.0 - initial release
// ============================================================================
module ssd_display_ctrl #(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 2**20,
    parameter int BLINK_TICKS = 8
) (
    input  logic                    clk,
    input  logic                    reset_N,
    ssd_display_ctrl_if.slave       bus,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    sweep_done
);
    localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [IW-1:0] IDX_MS = IW'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    pending_q, pending_d;
    logic [CW-1:0]           cnt_q;
    logic [BW-1:0]           blink_cnt_q;
    logic                    blink_off_q;

    logic                    w_tick;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic [6:0]              w_seg_out;
    logic                    w_lead_blank;

    assign w_tick = (cnt_q == CW'(REFRESH_DIV - 1));
    assign w_nib  = shadow_q[4*idx_q +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_q, lead_d;
    assign w_lead_blank = lead_q && (w_nib == 4'h0) && (idx_q != '0);
`else
    assign w_lead_blank = 1'b0;
`endif

    // Single shared decoder, active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;  4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;  4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;  4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;  4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;  4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;  4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;  4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;  4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    assign w_seg_out = (w_lead_blank || (blink_off_q && blink_mask[idx_q])) ? 7'h7F : w_seg;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        hex_d     = hex_q;
        pending_d = pending_q;
`ifdef LEADING_ZERO_BLANK_EN
        lead_d    = lead_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A tick landing with accepted data is absorbed by this one sweep
                if (bus.data_valid || w_tick || pending_q) begin
                    if (bus.data_valid) shadow_d = bus.data_in;
                    state_d   = ST_SCAN;
                    idx_d     = IDX_MS;
                    pending_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                    lead_d    = 1'b1;
`endif
                end
            end
            ST_SCAN: begin
                hex_d[7*idx_q +: 7] = w_seg_out;
`ifdef LEADING_ZERO_BLANK_EN
                if (w_nib != 4'h0) lead_d = 1'b0;
`endif
                if (idx_q == '0) state_d = ST_DONE;
                else             idx_d   = idx_q - 1'b1;
                if (w_tick) pending_d = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (w_tick) pending_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_MS;
            shadow_q    <= '0;
            hex_q       <= '1;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            hex_q     <= hex_d;
            pending_q <= pending_d;
            cnt_q     <= w_tick ? '0 : cnt_q + 1'b1;
            if (w_tick) begin
                if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt_q <= '0;
                    blink_off_q <= ~blink_off_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) lead_q <= 1'b1;
        else          lead_q <= lead_d;
    end
`endif

    assign bus.data_ready = (state_q == ST_IDLE);
    assign sweep_done     = (state_q == ST_DONE);
    assign hex_out        = hex_q;
endmodule
`default_nettype wire
